// File: rtl/uart_msg_receiver.sv
// uart_msg_receiver: oversampling 8N1 UART receiver that packs BYTES_PER_MSG
// bytes (first byte in MSBs) into a message word and pulses isNew per message.
module uart_msg_receiver #(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned BYTES_PER_MSG = 2,
    parameter int unsigned TIMEOUT_BITS  = 20
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       serialIn,
    output logic [8*BYTES_PER_MSG-1:0] message,
    output logic                       isNew,
    output logic                       frameError
);

    localparam int unsigned MSG_W    = 8 * BYTES_PER_MSG;
    localparam int unsigned CYC_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TO_W     = (TO_LIMIT == 0) ? 1 : $clog2(TO_LIMIT + 1);
    localparam int unsigned CNT_W    = $clog2(BYTES_PER_MSG + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         sync;
    logic               rx;
    logic [CYC_W-1:0]   cyc;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic [MSG_W-1:0]   asm_word;
    logic [MSG_W-1:0]   asm_next;
    logic [CNT_W-1:0]   byte_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               cyc_last;
    logic               start_hit;
    logic               data_sample;
    logic               byte_ok;
    logic               byte_bad;
    logic               timeout_hit;

    assign rx        = sync[1];
    assign cyc_last  = (cyc == CYC_W'(CLKS_PER_BIT - 1));
    assign start_hit = (cyc == CYC_W'(CLKS_PER_BIT / 2 - 1));
    assign asm_next  = MSG_W'({asm_word, shreg});
    assign timeout_hit = (TO_LIMIT != 0) && (state == S_IDLE) && (byte_cnt != '0)
                         && (to_cnt == TO_W'(TO_LIMIT - 1));

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge clock) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], serialIn};
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic and per-cycle sampling strobes
    always_comb begin
        state_next  = state;
        data_sample = 1'b0;
        byte_ok     = 1'b0;
        byte_bad    = 1'b0;
        case (state)
            S_IDLE:  if (!rx) state_next = S_START;
            S_START: if (start_hit) state_next = rx ? S_IDLE : S_DATA;
            S_DATA: begin
                if (cyc_last) begin
                    data_sample = 1'b1;
                    if (bit_idx == 3'd7) state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (cyc_last) begin
                    if (rx) begin
                        byte_ok    = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        byte_bad   = 1'b1;
                        state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: if (rx) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Bit timing, byte shifting, message assembly, timeout and output pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            asm_word   <= '0;
            byte_cnt   <= '0;
            to_cnt     <= '0;
            message    <= '0;
            isNew      <= 1'b0;
            frameError <= 1'b0;
        end else begin
            isNew      <= 1'b0;
            frameError <= byte_bad;

            if (state_next != state || state == S_IDLE || state == S_BREAK || data_sample)
                cyc <= '0;
            else
                cyc <= cyc + CYC_W'(1);

            if (state != S_DATA)  bit_idx <= '0;
            else if (data_sample) bit_idx <= bit_idx + 3'd1;

            if (data_sample) shreg <= {rx, shreg[7:1]};

            if (byte_bad) begin
                byte_cnt <= '0;
            end else if (byte_ok) begin
                asm_word <= asm_next;
                if (byte_cnt == CNT_W'(BYTES_PER_MSG - 1)) begin
                    message  <= asm_next;
                    isNew    <= 1'b1;
                    byte_cnt <= '0;
                end else begin
                    byte_cnt <= byte_cnt + CNT_W'(1);
                end
            end else if (timeout_hit) begin
                byte_cnt <= '0;
            end

            if (state != S_IDLE || byte_cnt == '0 || timeout_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_msg_receiver.sv
// Scoreboard bench for uart_msg_receiver: two-byte instance plus a one-byte instance.
module tb_uart_msg_receiver;

    localparam int unsigned CPB = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        rxd0, rxd1;
    logic [15:0] message0;
    logic        isNew0, fe0;
    logic [7:0]  message1;
    logic        isNew1, fe1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic        err;
        logic [15:0] msg;
    } exp_t;

    exp_t       q0[$];
    logic [7:0] q1[$];
    logic [7:0] pend[$];
    int         t1[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_msg_receiver #(.CLKS_PER_BIT(CPB), .BYTES_PER_MSG(2), .TIMEOUT_BITS(20)) dut0 (
        .clock(clock), .reset(reset), .serialIn(rxd0),
        .message(message0), .isNew(isNew0), .frameError(fe0)
    );

    uart_msg_receiver #(.CLKS_PER_BIT(CPB), .BYTES_PER_MSG(1), .TIMEOUT_BITS(20)) dut1 (
        .clock(clock), .reset(reset), .serialIn(rxd1),
        .message(message1), .isNew(isNew1), .frameError(fe1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: collect accepted bytes, emit a word when enough are held
    task automatic model_good(input logic [7:0] b);
        exp_t e;
        pend.push_back(b);
        if (pend.size() == 2) begin
            e.err = 1'b0;
            e.msg = {pend[0], pend[1]};
            q0.push_back(e);
            pend.delete();
        end
    endtask

    task automatic model_bad();
        exp_t e;
        pend.delete();
        e.err = 1'b1;
        e.msg = 16'h0;
        q0.push_back(e);
    endtask

    task automatic set_line(input bit ch, input logic v);
        if (ch) rxd1 = v;
        else    rxd0 = v;
    endtask

    task automatic send_frame(input bit ch, input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            set_line(ch, f[i]);
            repeat (CPB) @(negedge clock);
        end
        set_line(ch, 1'b1);
    endtask

    task automatic idle(input bit ch, input int nbits);
        set_line(ch, 1'b1);
        repeat (nbits * CPB) @(negedge clock);
    endtask

    task automatic good(input logic [7:0] b);
        model_good(b);
        send_frame(1'b0, b, 1'b1);
    endtask

    task automatic bad(input logic [7:0] b);
        model_bad();
        send_frame(1'b0, b, 1'b0);
        idle(1'b0, 1);
    endtask

    task automatic glitch();
        rxd0 = 1'b0;
        repeat (4) @(negedge clock);
        rxd0 = 1'b1;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic long_gap();
        pend.delete();
        idle(1'b0, 25);
    endtask

    task automatic drain0(input string name);
        for (int i = 0; i < 2000 && q0.size() != 0; i++) @(negedge clock);
        check(name, 32'(q0.size()), 32'd0);
    endtask

    // Monitor for the two-byte instance
    always @(negedge clock) begin
        exp_t e;
        if (isNew0 || fe0) begin
            check("pulse_exclusive", 32'(isNew0 & fe0), 32'd0);
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse0: got isNew=%0b frameError=%0b expected none (cycle %0d)",
                         isNew0, fe0, cyc);
            end else begin
                e = q0.pop_front();
                check("pulse_kind0", 32'(fe0), 32'(e.err));
                if (isNew0) check("message0", 32'(message0), 32'(e.msg));
            end
        end
    end

    // Monitor for the one-byte instance
    always @(negedge clock) begin
        logic [7:0] b;
        if (fe1) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame_error1: got 1 expected 0 (cycle %0d)", cyc);
        end
        if (isNew1) begin
            t1.push_back(cyc);
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse1: got isNew=1 expected none (cycle %0d)", cyc);
            end else begin
                b = q1.pop_front();
                check("message1", 32'(message1), 32'(b));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r0;
        logic [7:0] bytes1[4];
        reset = 1'b1;
        rxd0  = 1'b1;
        rxd1  = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_message0", 32'(message0), 32'd0);
        check("reset_isNew0", 32'(isNew0), 32'd0);
        check("reset_frameError0", 32'(fe0), 32'd0);
        check("reset_message1", 32'(message1), 32'd0);
        idle(1'b0, 2);

        // Back-to-back two-byte message
        good(8'h48);
        good(8'h65);
        idle(1'b0, 2);

        // Bad stop bit drops the byte; following pair still assembles
        bad(8'h41);
        idle(1'b0, 1);
        good(8'h42);
        good(8'h43);
        idle(1'b0, 2);

        // Short low glitch is ignored
        glitch();
        good(8'h61);
        good(8'h62);
        idle(1'b0, 2);

        // Partial message dropped after a long idle
        good(8'h31);
        long_gap();
        good(8'h32);
        good(8'h33);
        idle(1'b0, 2);
        drain0("drain_directed");

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int unsigned k;
            k  = $urandom_range(0, 9);
            r0 = 8'($urandom);
            case (k)
                0:       bad(r0);
                1:       glitch();
                2:       long_gap();
                default: good(r0);
            endcase
            idle(1'b0, int'($urandom_range(0, 3)));
        end
        idle(1'b0, 2);
        drain0("drain_random");

        // Reset during bit 4 of the second byte
        long_gap();
        good(8'hA5);
        r0 = 8'h3C;
        rxd0 = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rxd0 = r0[i];
            repeat (CPB) @(negedge clock);
        end
        rxd0 = r0[4];
        repeat (CPB / 2) @(negedge clock);
        reset = 1'b1;
        rxd0  = 1'b1;
        pend.delete();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midframe_reset_message", 32'(message0), 32'd0);
        check("midframe_reset_isNew", 32'(isNew0), 32'd0);
        idle(1'b0, 2);
        good(8'hC3);
        good(8'h5A);
        idle(1'b0, 2);
        drain0("drain_after_reset");

        // One byte per message: every byte pulses, back-to-back spacing is 10 bit-times
        bytes1[0] = 8'h7A;
        bytes1[1] = 8'h20;
        bytes1[2] = 8'($urandom);
        bytes1[3] = 8'($urandom);
        t1.delete();
        for (int i = 0; i < 4; i++) begin
            q1.push_back(bytes1[i]);
            send_frame(1'b1, bytes1[i], 1'b1);
        end
        idle(1'b1, 2);
        for (int i = 0; i < 2000 && q1.size() != 0; i++) @(negedge clock);
        check("drain1", 32'(q1.size()), 32'd0);
        check("pulse_count1", 32'(t1.size()), 32'd4);
        if (t1.size() >= 2) check("pulse_spacing1", 32'(t1[1] - t1[0]), 32'(10 * CPB));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
